rf_wb_sched: RTL and testbench

RF_WB_SCHED -- requirements
Module: rf_wb_sched

---
 rtl/rf_wb_sched_pkg.sv | 14 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/rf_wb_sched.sv | 93 +++++++++
 tb/tb_rf_wb_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_sched_pkg.sv
// Shared widths and requester encoding for the
// register-file writeback scheduler.
package rf_wb_sched_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational
// grant, one flop remembering the last winner.
module rr_arb2
  import rf_wb_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_m,
  output logic o_gnt_a,
  output logic o_gnt_m
);

  req_e r_last;

  // ties go to whoever did not win last time
  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_m = 1'b0;
    if (!rst) begin
      if (i_req_a && i_req_m) begin
        o_gnt_a = (r_last == REQ_MEM);
        o_gnt_m = (r_last == REQ_ALU);
      end else begin
        o_gnt_a = i_req_a;
        o_gnt_m = i_req_m;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ_MEM;
    end else if (o_gnt_a) begin
      r_last <= REQ_ALU;
    end else if (o_gnt_m) begin
      r_last <= REQ_MEM;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Scoreboard plus single write port shared by the
// ALU and memory writeback paths.
module rf_wb_sched #(
  parameter  int XLEN  = rf_wb_sched_pkg::XLEN,
  parameter  int NREGS = rf_wb_sched_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  output logic             iss_stall,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_rd,
  input  logic [XLEN-1:0]  a_data,
  output logic             a_ready,
  input  logic             m_valid,
  input  logic [AW-1:0]    m_rd,
  input  logic [XLEN-1:0]  m_data,
  output logic             m_ready,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0] r_pending;
  logic             r_we;
  logic [AW-1:0]    r_wa;
  logic [XLEN-1:0]  r_wd;

  logic             w_ga;
  logic             w_gm;
  logic             w_accept;
  logic             w_wr;
  logic [AW-1:0]    w_rd;
  logic [XLEN-1:0]  w_data;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req_a (a_valid),
    .i_req_m (m_valid),
    .o_gnt_a (w_ga),
    .o_gnt_m (w_gm)
  );

  // clearing bits are deliberately not bypassed
  assign iss_stall = iss_valid & (
      ((|iss_rs1) & r_pending[iss_rs1])
    | ((|iss_rs2) & r_pending[iss_rs2])
    | ((|iss_rd)  & r_pending[iss_rd]));

  assign w_accept = iss_valid & ~iss_stall;
  assign w_rd     = w_gm ? m_rd   : a_rd;
  assign w_data   = w_gm ? m_data : a_data;
  assign w_wr     = (w_ga | w_gm) & (|w_rd);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_accept && (|iss_rd)) w_set[iss_rd] = 1'b1;
    if (w_wr) w_clr[w_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wd      <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_we      <= w_wr;
      if (w_wr) begin
        r_wa <= w_rd;
        r_wd <= w_data;
      end
    end
  end

  assign a_ready = w_ga;
  assign m_ready = w_gm;
  assign rf_we   = r_we;
  assign rf_wa   = r_wa;
  assign rf_wd   = r_wd;
  assign pending = r_pending;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed and randomized bench for rf_wb_sched
// against a per-cycle behavioural model.
module tb_rf_wb_sched;

  localparam int XLEN  = 32;
  localparam int NREGS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid;
  logic [2:0]      iss_rd, iss_rs1, iss_rs2;
  logic            iss_stall;
  logic            a_valid, m_valid;
  logic [2:0]      a_rd, m_rd;
  logic [XLEN-1:0] a_data, m_data;
  logic            a_ready, m_ready;
  logic            rf_we;
  logic [2:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [NREGS-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit              mp[NREGS];
  bit              alu_turn;
  bit              e_we;
  logic [2:0]      e_wa;
  logic [XLEN-1:0] e_wd;
  bit              g_alu, g_mem;

  always #5 clk = ~clk;

  rf_wb_sched dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .m_valid   (m_valid),
    .m_rd      (m_rd),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .pending   (pending)
  );

  task automatic chk(string tag,
                     logic [XLEN-1:0] obs,
                     logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREGS-1:0] mvec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = mp[i];
    return v;
  endfunction

  function automatic bit busy(logic [2:0] r);
    return (r != 0) && mp[r];
  endfunction

  // one clock: check comb outputs, step model, check regs
  task automatic cyc();
    bit stall, acc;
    logic [2:0] wr;
    logic [XLEN-1:0] wd;
    @(negedge clk);
    stall = iss_valid &&
      (busy(iss_rs1) || busy(iss_rs2) || busy(iss_rd));
    g_alu = 0;
    g_mem = 0;
    if (!rst) begin
      if (a_valid && m_valid) begin
        if (alu_turn) g_alu = 1; else g_mem = 1;
      end else begin
        g_alu = a_valid;
        g_mem = m_valid;
      end
    end
    chk("iss_stall", 32'(iss_stall), 32'(stall));
    chk("a_ready", 32'(a_ready), 32'(g_alu));
    chk("m_ready", 32'(m_ready), 32'(g_mem));
    acc = iss_valid && !stall;
    wr = g_mem ? m_rd : a_rd;
    wd = g_mem ? m_data : a_data;
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (mp[i]) mp[i] = 0;
      alu_turn = 1;
      e_we = 0;
      e_wa = 0;
      e_wd = 0;
    end else begin
      e_we = 0;
      if (g_alu || g_mem) begin
        alu_turn = g_mem;
        if (wr != 0) begin
          e_we = 1;
          e_wa = wr;
          e_wd = wd;
          mp[wr] = 0;
        end
      end
      if (acc && iss_rd != 0) mp[iss_rd] = 1;
    end
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_wa", 32'(rf_wa), 32'(e_wa));
    chk("rf_wd", rf_wd, e_wd);
    chk("pending", 32'(pending), 32'(mvec()));
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = 0;
    iss_rs1 = 0; iss_rs2 = 0;
    a_valid = 0; a_rd = 0; a_data = 0;
    m_valid = 0; m_rd = 0; m_data = 0;
  endtask

  task automatic issue(logic [2:0] rd,
                       logic [2:0] s1,
                       logic [2:0] s2);
    iss_valid = 1; iss_rd = rd;
    iss_rs1 = s1; iss_rs2 = s2;
  endtask

  initial begin
    bit hold_a, hold_m;
    foreach (mp[i]) mp[i] = 0;
    alu_turn = 1;
    e_we = 0; e_wa = 0; e_wd = 0;
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;

    // reserve r3, then a reader of r3 stalls
    issue(3, 0, 0); cyc();
    chk("pend_r3", 32'(pending), 32'h08);
    issue(1, 3, 0); cyc();
    issue(5, 0, 0); cyc();
    idle();

    // tie: ALU first, then MEM
    a_valid = 1; a_rd = 3; a_data = 32'h1111;
    m_valid = 1; m_rd = 5; m_data = 32'h5555;
    cyc();
    chk("tie1_wa", 32'(rf_wa), 32'd3);
    a_rd = 6; a_data = 32'h6666;
    cyc();
    chk("tie2_wa", 32'(rf_wa), 32'd5);
    idle();

    // MEM alone three times, then tie goes to ALU
    m_valid = 1;
    for (int i = 0; i < 3; i++) begin
      m_rd = 3'(i + 1); m_data = 32'(i * 7); cyc();
    end
    a_valid = 1; a_rd = 7; a_data = 32'h7777;
    m_rd = 2; cyc();
    chk("tie3_wa", 32'(rf_wa), 32'd7);
    idle();
    cyc();

    // write and reserve of r4 on the same edge
    issue(4, 0, 0);
    a_valid = 1; a_rd = 4; a_data = 32'hDEADBEEF;
    cyc();
    chk("same_wd", rf_wd, 32'hDEADBEEF);
    chk("same_p4", 32'(pending[4]), 32'd1);
    idle();

    // rd=0 write and rd=0 issue
    a_valid = 1; a_rd = 0; a_data = 32'hAB;
    issue(0, 0, 0);
    cyc();
    idle();

    // reset right after a grant
    a_valid = 1; a_rd = 2; a_data = 32'h22;
    issue(6, 0, 0);
    cyc();
    idle();
    rst = 1;
    cyc();
    rst = 0;
    a_valid = 1; a_rd = 1; a_data = 32'h10;
    m_valid = 1; m_rd = 2; m_data = 32'h20;
    cyc();
    chk("post_rst_wa", 32'(rf_wa), 32'd1);
    idle();

    // randomized traffic with request hold
    hold_a = 0;
    hold_m = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_rd  = 3'($urandom);
      iss_rs1 = 3'($urandom);
      iss_rs2 = 3'($urandom);
      if (!hold_a) begin
        a_valid = $urandom_range(0, 1);
        a_rd = 3'($urandom); a_data = $urandom;
      end
      if (!hold_m) begin
        m_valid = $urandom_range(0, 1);
        m_rd = 3'($urandom); m_data = $urandom;
      end
      cyc();
      hold_a = a_valid && !g_alu;
      hold_m = m_valid && !g_mem;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
